// File: rtl/nexys_starship_director.sv
// Game director for the four monster FSMs: global IDLE/PLAY/OVER state, LFSR spawn
// strobes, per-direction shield timers and the saturating score counter.

module nexys_starship_shield_lane #(
  parameter int SHIELD_HOLD = 2
) (
  input  logic timer_clk,
  input  logic Reset,
  input  logic en,
  input  logic press,
  output logic active
);
  logic [3:0] cnt;

  // A press reloads rather than accumulates, so holding the button cannot stack time.
  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset)              cnt <= '0;
    else if (!en)           cnt <= '0;
    else if (press)         cnt <= 4'(SHIELD_HOLD);
    else if (cnt != 4'd0)   cnt <= cnt - 4'd1;
  end

  assign active = (cnt != 4'd0);
endmodule

module nexys_starship_director #(
  parameter int          SHIELD_HOLD = 2,
  parameter int          RAND_THRESH = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       timer_clk,
  input  logic       Reset,
  input  logic       start_btn,
  input  logic [3:0] shield_btn,
  input  logic [3:0] monster,
  input  logic [3:0] monster_gameover,
  output logic       play_flag,
  output logic [3:0] shield,
  output logic [3:0] random,
  output logic       gameover_ctrl,
  output logic [7:0] score,
  output logic       q_Idle,
  output logic       q_Play,
  output logic       q_Over
);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    PLAY = 3'b010,
    OVER = 3'b100
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  mon_s1, mon_s2, mon_prev;
  logic [3:0]  go_s1, go_s2;
  logic [15:0] lfsr;
  logic [3:0]  rand_nxt;
  logic [3:0]  falls;
  logic [2:0]  nfalls;
  logic [8:0]  score_sum;
  logic [7:0]  score_nxt;

  // The monster FSMs run on the fast clock; bring their flags over before use.
  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) begin
      mon_s1   <= '0;
      mon_s2   <= '0;
      mon_prev <= '0;
      go_s1    <= '0;
      go_s2    <= '0;
    end else begin
      mon_s1   <= monster;
      mon_s2   <= mon_s1;
      mon_prev <= mon_s2;
      go_s1    <= monster_gameover;
      go_s2    <= go_s1;
    end
  end

  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_btn)     state_nxt = PLAY;
      PLAY:    if (go_s2 != 4'd0) state_nxt = OVER;
      OVER:    if (start_btn)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  assign q_Idle        = state[0];
  assign q_Play        = state[1];
  assign q_Over        = state[2];
  assign play_flag     = q_Play;
  assign gameover_ctrl = q_Over;

  // Galois LFSR free-runs in every state so the spawn pattern differs per game.
  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) lfsr <= SEED;
    else       lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  for (genvar i = 0; i < 4; i++) begin : g_dir
    assign rand_nxt[i] = (state == PLAY) && (lfsr[4*i +: 4] < 4'(RAND_THRESH));

    nexys_starship_shield_lane #(.SHIELD_HOLD(SHIELD_HOLD)) u_shield (
      .timer_clk (timer_clk),
      .Reset     (Reset),
      .en        (state == PLAY),
      .press     (shield_btn[i]),
      .active    (shield[i])
    );
  end

  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) random <= '0;
    else       random <= rand_nxt;
  end

  // Falls on the same edge as the gameover transition still land, since state is PLAY then.
  always_comb begin
    falls     = mon_prev & ~mon_s2;
    nfalls    = 3'($countones(falls));
    score_sum = {1'b0, score} + {6'd0, nfalls};
    score_nxt = score;
    if (state == PLAY)
      score_nxt = score_sum[8] ? 8'hFF : score_sum[7:0];
    else if (state == OVER && start_btn)
      score_nxt = '0;
  end

  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) score <= '0;
    else       score <= score_nxt;
  end
endmodule

// File: doc/nexys_starship_director.md
Name: nexys_starship_director

Overview:
- Game-side counterpart to the four monster FSMs (left/right/top/bottom).
- Runs the global game state and generates the signals each monster FSM consumes: play_flag, per-direction random spawn strobes, per-direction shield levels and gameover_ctrl.
- Consumes each FSM's monster and gameover outputs and keeps the score.
- Runs on the slow timer_clk so every level it drives is held for at least one full timer period in the fast Clk domain.

Parameters:
- SHIELD_HOLD, 2: timer_clk cycles a shield stays asserted after a button pulse; legal range 1..15.
- RAND_THRESH, 4: 4-bit spawn threshold; random[i] = 1 when the LFSR nibble is below RAND_THRESH (4 gives 25%).
- LFSR_SEED, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- timer_clk  in  1  slow game clock
- Reset  in  1  asynchronous, active-high
- start_btn  in  1  one-cycle pulse, debounced, synchronous to timer_clk
- shield_btn  in  4  one-cycle pulses, synchronous to timer_clk; bit0 left, bit1 right, bit2 top, bit3 bottom
- monster  in  4  monster-present flags from the four FSMs (Clk domain); same bit order
- monster_gameover  in  4  gameover flags from the four FSMs (Clk domain)
- play_flag  out  1  high in PLAY
- shield  out  4  per-direction shield level
- random  out  4  per-direction spawn strobe
- gameover_ctrl  out  1  high in OVER
- score  out  8  monsters cleared, saturating
- q_Idle, q_Play, q_Over  out  1 each  one-hot state outputs

Behaviour:
- Reset (async, immediate, also mid-game): state IDLE, q_Idle=1, play_flag=0, shield=0, random=0, gameover_ctrl=0, score=0, all shield counters=0, LFSR=seed.
- Synchronizers: monster and monster_gameover each pass through a 2-flop synchronizer on timer_clk; "synced" below means the second stage. A third register holds the previous synced monster value for fall detection. Synchronizer flops are cleared by Reset.
- State machine (one-hot, 3 bits, states IDLE/PLAY/OVER):
  - IDLE: start_btn -> PLAY.
  - PLAY: any synced monster_gameover bit = 1 -> OVER. start_btn is ignored.
  - OVER: start_btn -> IDLE; score clears on that transition.
  - An illegal encoding -> IDLE.
- Outputs decoded from the state register:
  - play_flag = q_Play.
  - gameover_ctrl = q_Over; held for as long as the state is OVER.
  - Both change in the cycle after the triggering edge.
- LFSR:
  - 16-bit Galois, mask 16'hB400, shift right, advances every timer_clk edge in all states.
  - random register at each edge: if state == PLAY, random[i] <= (lfsr[4i+3:4i] < RAND_THRESH), using the current LFSR value; otherwise random <= 0.
  - Result: random is 0 in the first cycle of PLAY and returns to 0 one cycle after leaving PLAY.
- Shield, per direction i, 4-bit counter:
  - In PLAY, shield_btn[i] = 1 loads SHIELD_HOLD. A press while the counter is nonzero reloads it; there is no accumulation.
  - Otherwise a nonzero counter decrements.
  - Outside PLAY, counters are forced to 0.
  - shield[i] = (counter != 0), so a press at edge N gives shield high for exactly SHIELD_HOLD cycles.
  - Simultaneous presses on several directions are all accepted.
- Score:
  - In PLAY, each synced monster bit falling 1->0 counts as one clear.
  - The number of falls in one cycle (0..4) is added to score, saturating at 255.
  - Falls in the same cycle as a gameover transition are still counted.
  - Score holds in OVER and clears on OVER->IDLE and on Reset.
- Latency:
  - Monster or gameover change to internal effect: 2 timer_clk edges of synchronization, plus 1 edge for the registered response.

Test Plan:
- Reset mid-PLAY with shield=4'b0001, score=7 -> all outputs return to reset values immediately; q_Idle=1.
- start_btn in IDLE -> q_Play=1 and play_flag=1 after 1 edge; random=0 that cycle; afterwards random matches a Galois 16'hB400 model seeded 16'hACE1 with threshold 4; random stays 0 in IDLE.
- SHIELD_HOLD=2, shield_btn=4'b0100 at edge N -> shield=4'b0100 for 2 cycles, then 0; a second press at N+1 extends shield to end after N+3; a press in IDLE -> shield stays 0.
- monster goes 4'b0011 then 4'b0000 in PLAY -> score +2 three edges after the fall; 260 single falls -> score saturates at 255.
- monster_gameover[3]=1 held -> q_Over and gameover_ctrl=1 within 3 edges; random and shield go to 0; score retained; start_btn -> IDLE with score=0; a second start_btn -> PLAY.
- monster falls in the same cycle gameover is synced -> state OVER and score incremented by 1.
